// File: rtl/bsg_and_accum_pkg.sv
// Shared types for the AND accumulator: frame FSM state encoding.
package bsg_and_accum_pkg;

    typedef enum logic {
        eAccum = 1'b0,
        eHold  = 1'b1
    } bsg_and_accum_state_e;

    // Width of a counter that must represent 0..els inclusive.
    function automatic int unsigned bsg_and_accum_cnt_width(input int unsigned els);
        return (els + 1 > 1) ? $clog2(els + 1) : 1;
    endfunction

endpackage

// File: rtl/bsg_and_accum_ctr.sv
// Beat counter for one frame: synchronous clear, increment, and final-beat flag.
module bsg_and_accum_ctr
    import bsg_and_accum_pkg::*;
#(
    parameter int unsigned els_p = 4,
    localparam int unsigned lg_els_lp = bsg_and_accum_cnt_width(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 incr_i,
    output logic [lg_els_lp-1:0] cnt_o,
    output logic                 final_o
);

    logic [lg_els_lp-1:0] cnt_r;

    // Count accepted beats; clear wins so a final beat restarts the frame at zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (incr_i) begin
            cnt_r <= cnt_r + lg_els_lp'(1);
        end
    end

    // The next accepted beat is the last one the frame can hold.
    always_comb begin
        cnt_o   = cnt_r;
        final_o = (cnt_r == lg_els_lp'(els_p - 1));
    end

endmodule

// File: rtl/bsg_and_accum.sv
// Folds a stream of words into one word per frame by bitwise AND.
// A frame closes after els_p beats or on a beat with last_i set.
module bsg_and_accum
    import bsg_and_accum_pkg::*;
#(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = 4,
    localparam int unsigned lg_els_lp = bsg_and_accum_cnt_width(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    input  logic [width_p-1:0]   data_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    output logic [lg_els_lp-1:0] count_o,
    input  logic                 yumi_i
);

    bsg_and_accum_state_e state_r, state_n;

    logic [width_p-1:0]   acc_r;
    logic [width_p-1:0]   data_r;
    logic [lg_els_lp-1:0] count_r;
    logic [lg_els_lp-1:0] cnt;
    logic                 cnt_final;
    logic                 accept;
    logic                 final_beat;

    // ready_o depends on state only, so no path from yumi_i reaches it.
    assign accept     = v_i & ready_o;
    assign final_beat = accept & (cnt_final | last_i);

    bsg_and_accum_ctr #(
        .els_p (els_p)
    ) u_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (final_beat),
        .incr_i    (accept),
        .cnt_o     (cnt),
        .final_o   (cnt_final)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eAccum;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state: hold a finished frame until the consumer takes it.
    always_comb begin
        state_n = state_r;
        case (state_r)
            eAccum:  if (final_beat) state_n = eHold;
            eHold:   if (yumi_i)     state_n = eAccum;
            default: state_n = eAccum;
        endcase
    end

    // Outputs decoded from state and the result registers.
    always_comb begin
        v_o     = (state_r == eHold);
        ready_o = (state_r == eAccum);
        data_o  = data_r;
        count_o = count_r;
    end

    // AND datapath: accumulator restarts at all-ones (AND identity) after each frame.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_r   <= '1;
            data_r  <= '0;
            count_r <= '0;
        end else if (final_beat) begin
            acc_r   <= '1;
            data_r  <= acc_r & data_i;
            count_r <= cnt + lg_els_lp'(1);
        end else if (accept) begin
            acc_r   <= acc_r & data_i;
        end
    end

    // The consumer may only take a result that is being offered.
    a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("bsg_and_accum: yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_bsg_and_accum.sv
// Directed bench for bsg_and_accum: one instance with els_p=4, one with els_p=1.
module tb_bsg_and_accum;

    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic         v_i = 1'b0, last_i = 1'b0, yumi_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_o, v_o;
    logic [W-1:0] data_o;
    logic [2:0]   count_o;

    logic         v1_i = 1'b0, last1_i = 1'b0, yumi1_i = 1'b0;
    logic [W-1:0] data1_i = '0;
    logic         ready1_o, v1_o;
    logic [W-1:0] data1_o;
    logic [0:0]   count1_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_and_accum #(.width_p(W), .els_p(4)) u_dut4 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .last_i    (last_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .count_o   (count_o),
        .yumi_i    (yumi_i)
    );

    bsg_and_accum #(.width_p(W), .els_p(1)) u_dut1 (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v1_i),
        .data_i    (data1_i),
        .last_i    (last1_i),
        .ready_o   (ready1_o),
        .v_o       (v1_o),
        .data_o    (data1_o),
        .count_o   (count1_o),
        .yumi_i    (yumi1_i)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        v_i = 1'b1; data_i = d; last_i = l;
        step();
        v_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic pop();
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o got %b want 0", v_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_o got %b want 1", ready_o); end
        n_cmp++; if (data_o !== 64'h0) begin n_err++; $display("FAIL reset_data_o got %h want 0", data_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count_o got %0d want 0", count_o); end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL idle_v_o cyc %0d got %b want 0", i, v_o); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] beats [4];
        beats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        beats[1] = 64'h0F0F_0F0F_0F0F_0F0F;
        beats[2] = 64'hFF00_FF00_FF00_FF00;
        beats[3] = 64'h0000_FFFF_0000_FFFF;
        v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = beats[i];
            step();
            if (i == 2) begin
                n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL b2b_early_v_o got %b want 0", v_o); end
            end
        end
        v_i = 1'b0;
        n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL b2b_v_o got %b want 1", v_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready_o got %b want 0", ready_o); end
        n_cmp++; if (data_o !== 64'h0000_0F00_0000_0F00) begin n_err++; $display("FAIL b2b_data got %h want 0000_0f00_0000_0f00", data_o); end
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL b2b_count got %0d want 4", count_o); end
        pop();
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL b2b_pop_v_o got %b want 0", v_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_pop_ready got %b want 1", ready_o); end
    endtask

    task automatic test_last();
        send_beat(64'h1234_5678_9ABC_DEF0, 1'b0);
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL last_early_v_o got %b want 0", v_o); end
        send_beat(64'hFFFF_0000_FFFF_0000, 1'b1);
        n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL last_v_o got %b want 1", v_o); end
        n_cmp++; if (data_o !== 64'h1234_0000_9ABC_0000) begin n_err++; $display("FAIL last_data got %h want 1234_0000_9abc_0000", data_o); end
        n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL last_count got %0d want 2", count_o); end
        pop();
    endtask

    task automatic test_backpressure();
        send_beat(64'h3C3C_3C3C_3C3C_3C3C, 1'b1);
        // Offer zero beats while held: accepting any of them would corrupt the next frame.
        v_i = 1'b1; data_i = 64'h0; last_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want 0", i, ready_o); end
            n_cmp++; if (v_o !== 1'b1 || data_o !== 64'h3C3C_3C3C_3C3C_3C3C || count_o !== 3'd1) begin
                n_err++; $display("FAIL bp_hold cyc %0d got v=%b d=%h c=%0d want v=1 d=3c3c3c3c3c3c3c3c c=1", i, v_o, data_o, count_o);
            end
        end
        pop();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b want 1", ready_o); end
        data_i = 64'h5A5A_5A5A_5A5A_5A5A; last_i = 1'b1;
        step();
        v_i = 1'b0; last_i = 1'b0;
        n_cmp++; if (v_o !== 1'b1 || data_o !== 64'h5A5A_5A5A_5A5A_5A5A || count_o !== 3'd1) begin
            n_err++; $display("FAIL bp_fresh got v=%b d=%h c=%0d want v=1 d=5a5a5a5a5a5a5a5a c=1", v_o, data_o, count_o);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        // Reset while a result is pending: it must vanish without a clock edge.
        send_beat(64'h0123_4567_89AB_CDEF, 1'b1);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (v_o !== 1'b0 || data_o !== 64'h0 || count_o !== 3'd0) begin
            n_err++; $display("FAIL rst_hold got v=%b d=%h c=%0d want v=0 d=0 c=0", v_o, data_o, count_o);
        end
        #2 reset_n = 1'b1;
        // Partial frame of zeros, then reset.
        step();
        send_beat(64'h0, 1'b0);
        send_beat(64'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++; $display("FAIL rst_frame got v=%b r=%b want v=0 r=1", v_o, ready_o);
        end
        #2 reset_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
            if (i == 2) begin
                n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rst_stale_v_o got %b want 0", v_o); end
            end
        end
        n_cmp++; if (v_o !== 1'b1 || data_o !== 64'hFFFF_FFFF_FFFF_FFFF || count_o !== 3'd4) begin
            n_err++; $display("FAIL rst_fresh got v=%b d=%h c=%0d want v=1 d=ffffffffffffffff c=4", v_o, data_o, count_o);
        end
        pop();
    endtask

    task automatic test_single_el();
        v1_i = 1'b1; data1_i = 64'hA5A5_A5A5_A5A5_A5A5; last1_i = 1'b0;
        step();
        v1_i = 1'b0;
        n_cmp++; if (v1_o !== 1'b1 || data1_o !== 64'hA5A5_A5A5_A5A5_A5A5 || count1_o !== 1'b1) begin
            n_err++; $display("FAIL el1_first got v=%b d=%h c=%0d want v=1 d=a5a5a5a5a5a5a5a5 c=1", v1_o, data1_o, count1_o);
        end
        yumi1_i = 1'b1;
        step();
        yumi1_i = 1'b0;
        n_cmp++; if (v1_o !== 1'b0 || ready1_o !== 1'b1) begin
            n_err++; $display("FAIL el1_pop got v=%b r=%b want v=0 r=1", v1_o, ready1_o);
        end
        v1_i = 1'b1; data1_i = 64'h0F0F_F0F0_1234_8765; last1_i = 1'b1;
        step();
        v1_i = 1'b0; last1_i = 1'b0;
        n_cmp++; if (v1_o !== 1'b1 || data1_o !== 64'h0F0F_F0F0_1234_8765 || count1_o !== 1'b1) begin
            n_err++; $display("FAIL el1_second got v=%b d=%h c=%0d want v=1 d=0f0ff0f012348765 c=1", v1_o, data1_o, count1_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_last();
        test_backpressure();
        test_reset_mid();
        test_single_el();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
